stdio_arb: RTL and testbench

STDIO_ARB -- requirements
Module: stdio_arb

---
 rtl/stdio_pkg.sv | 25 ++
 rtl/stdio_reg.sv | 47 ++++
 rtl/stdio_arb.sv | 125 ++++++++++++
 tb/tb_stdio_arb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/stdio_pkg.sv
// stdio_pkg: shared types and constants for the stdio stream arbiter.
//   owner_e  : current stream owner; the encoding doubles as the one-hot grant
//   STDIO_W  : stream data width
//   other_src: returns the competing requester for a given owner
package stdio_pkg;

    localparam int STDIO_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_SRC0 = 2'b01,
        OWN_SRC1 = 2'b10
    } owner_e;

    function automatic owner_e other_src(input owner_e o);
        owner_e r;
        case (o)
            OWN_SRC0: r = OWN_SRC1;
            OWN_SRC1: r = OWN_SRC0;
            default:  r = OWN_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stdio_reg.sv
// stdio_reg: one-entry registered output stage of the stdio stream.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : a new beat is accepted into the stage this cycle
//   data_i        : beat data to capture when load_i is high
//   rdy_i         : downstream ready
//   ld_o          : stage can take a beat this cycle (empty or draining)
//   val_o, data_o : registered output beat
module stdio_reg
    import stdio_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [STDIO_W-1:0] data_i,
    input  logic               rdy_i,
    output logic               ld_o,
    output logic               val_o,
    output logic [STDIO_W-1:0] data_o
);

    logic               val_q;
    logic [STDIO_W-1:0] data_q;

    // Accept-and-drain in the same cycle is allowed, so ld also follows rdy.
    assign ld_o   = !val_q || rdy_i;
    assign val_o  = val_q;
    assign data_o = data_q;

    // Output beat register; data holds while stalled or when nothing is loaded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q  <= 1'b0;
            data_q <= {STDIO_W{1'b0}};
        end else if (ld_o) begin
            val_q <= load_i;
            if (load_i) begin
                data_q <= data_i;
            end else begin
                data_q <= data_q;
            end
        end else begin
            val_q  <= val_q;
            data_q <= data_q;
        end
    end

endmodule

// File: rtl/stdio_arb.sv
// stdio_arb: two-source stream arbiter with burst limit onto one output stream.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   src0_* / src1_*     : requester streams (val/data in, rdy out)
//   stdout_*            : shared output stream (val/data out, rdy in)
//   grant_o             : one-hot registered owner (bit0 src0, bit1 src1)
//   busy_o              : output beat pending or an owner is held
module stdio_arb
    import stdio_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               src0_val_i,
    output logic               src0_rdy_o,
    input  logic [STDIO_W-1:0] src0_data_i,
    input  logic               src1_val_i,
    output logic               src1_rdy_o,
    input  logic [STDIO_W-1:0] src1_data_i,
    output logic               stdout_val_o,
    input  logic               stdout_rdy_i,
    output logic [STDIO_W-1:0] stdout_data_o,
    output logic [1:0]         grant_o,
    output logic               busy_o
);

    localparam int             CW      = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BURST_MAX);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    owner_e             owner_q;
    owner_e             last_q;
    logic [CW-1:0]      cnt_q;
    owner_e             sel_s;
    logic               ld_s;
    logic               accept_s;
    logic [STDIO_W-1:0] sel_data_s;

    // Source selection: alternate on ties from idle, hold the owner until its
    // burst budget is spent while the other source is waiting.
    always_comb begin
        sel_s = OWN_NONE;
        case (owner_q)
            OWN_SRC0: begin
                if (src0_val_i && (cnt_q < CNT_MAX || !src1_val_i)) begin
                    sel_s = OWN_SRC0;
                end else if (src1_val_i) begin
                    sel_s = OWN_SRC1;
                end else begin
                    sel_s = OWN_NONE;
                end
            end
            OWN_SRC1: begin
                if (src1_val_i && (cnt_q < CNT_MAX || !src0_val_i)) begin
                    sel_s = OWN_SRC1;
                end else if (src0_val_i) begin
                    sel_s = OWN_SRC0;
                end else begin
                    sel_s = OWN_NONE;
                end
            end
            default: begin
                if (src0_val_i && src1_val_i) begin
                    sel_s = other_src(last_q);
                end else if (src0_val_i) begin
                    sel_s = OWN_SRC0;
                end else if (src1_val_i) begin
                    sel_s = OWN_SRC1;
                end else begin
                    sel_s = OWN_NONE;
                end
            end
        endcase
    end

    // sel is only ever a valid source, so a selection while ld is a transfer.
    assign accept_s   = ld_s && (sel_s != OWN_NONE);
    assign sel_data_s = (sel_s == OWN_SRC1) ? src1_data_i : src0_data_i;

    // ld is high in reset (stage empty), so rdy is explicitly masked by rst_ni.
    assign src0_rdy_o = rst_ni && ld_s && (sel_s == OWN_SRC0);
    assign src1_rdy_o = rst_ni && ld_s && (sel_s == OWN_SRC1);

    // Ownership state machine with per-tenure beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            last_q  <= OWN_SRC1;
            cnt_q   <= {CW{1'b0}};
        end else if (accept_s) begin
            owner_q <= sel_s;
            last_q  <= sel_s;
            if (sel_s != owner_q) begin
                cnt_q <= CNT_ONE;
            end else if (cnt_q >= CNT_MAX) begin
                cnt_q <= CNT_MAX;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end else if (ld_s) begin
            owner_q <= OWN_NONE;
            last_q  <= last_q;
            cnt_q   <= {CW{1'b0}};
        end else begin
            owner_q <= owner_q;
            last_q  <= last_q;
            cnt_q   <= cnt_q;
        end
    end

    stdio_reg u_out (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (accept_s),
        .data_i (sel_data_s),
        .rdy_i  (stdout_rdy_i),
        .ld_o   (ld_s),
        .val_o  (stdout_val_o),
        .data_o (stdout_data_o)
    );

    assign grant_o = owner_q;
    assign busy_o  = stdout_val_o || (owner_q != OWN_NONE);

endmodule

// File: tb/tb_stdio_arb.sv
// tb_stdio_arb: directed self-checking bench for stdio_arb (BURST_MAX = 4).
module tb_stdio_arb;

    logic        clk;
    logic        rst_n;
    logic        v0, v1, r0, r1;
    logic [15:0] d0, d1;
    logic        ov, ordy;
    logic [15:0] od;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;

    stdio_arb #(.BURST_MAX(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .src0_val_i    (v0),
        .src0_rdy_o    (r0),
        .src0_data_i   (d0),
        .src1_val_i    (v1),
        .src1_rdy_o    (r1),
        .src1_data_i   (d1),
        .stdout_val_o  (ov),
        .stdout_rdy_i  (ordy),
        .stdout_data_o (od),
        .grant_o       (grant),
        .busy_o        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] n0, n1;
        int          es;

        // Reset with everything requesting: rdy must stay masked.
        rst_n = 1'b0; ordy = 1'b1;
        v0 = 1'b1; d0 = 16'h0041; v1 = 1'b1; d1 = 16'h0101;
        #2;
        chk("rst_rdy0", 32'(r0), 32'd0);
        chk("rst_rdy1", 32'(r1), 32'd0);
        chk("rst_val", 32'(ov), 32'd0);
        chk("rst_data", 32'(od), 32'h0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();

        // Release away from the edge; tie in first cycle goes to src0.
        rst_n = 1'b1;
        #1;
        chk("tie_rdy0", 32'(r0), 32'd1);
        chk("tie_rdy1", 32'(r1), 32'd0);
        chk("tie_val_pre", 32'(ov), 32'd0);
        tick();
        chk("tie_data", 32'(od), 32'h0041);
        chk("tie_val", 32'(ov), 32'd1);
        chk("tie_grant", 32'(grant), 32'b01);
        chk("tie_cnt", 32'(dut.cnt_q), 32'd1);

        // Single source src0 continues with 0x42, 0x43.
        v1 = 1'b0;
        d0 = 16'h0042; #1;
        chk("single_rdy1", 32'(r1), 32'd0);
        tick();
        chk("single_data42", 32'(od), 32'h0042);
        chk("single_grant", 32'(grant), 32'b01);
        d0 = 16'h0043; #1;
        chk("single_rdy1b", 32'(r1), 32'd0);
        tick();
        chk("single_data43", 32'(od), 32'h0043);
        chk("single_cnt", 32'(dut.cnt_q), 32'd3);
        v0 = 1'b0;
        tick();
        chk("idle_val", 32'(ov), 32'd0);
        chk("idle_grant", 32'(grant), 32'b00);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cnt", 32'(dut.cnt_q), 32'd0);

        // Lone src1 burst of 10: no gap, no switch, cnt saturates at 4.
        v1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d1 = 16'h0200 + 16'(i);
            #1;
            chk("lone_rdy1", 32'(r1), 32'd1);
            tick();
            chk("lone_data", 32'(od), 32'h0200 + 32'(i));
            chk("lone_val", 32'(ov), 32'd1);
            chk("lone_grant", 32'(grant), 32'b10);
            chk("lone_cnt", 32'(dut.cnt_q), (i < 3) ? 32'(i + 1) : 32'd4);
        end
        v1 = 1'b0;
        tick();
        chk("lone_end_val", 32'(ov), 32'd0);

        // Both continuously valid: 4 src0, 4 src1, 4 src0 (last was src1).
        n0 = 16'h0300; n1 = 16'h0400;
        for (int j = 0; j < 12; j++) begin
            es = ((j / 4) % 2 == 0) ? 0 : 1;
            v0 = 1'b1; d0 = n0; v1 = 1'b1; d1 = n1;
            #1;
            chk("burst_rdy0", 32'(r0), (es == 0) ? 32'd1 : 32'd0);
            chk("burst_rdy1", 32'(r1), (es == 1) ? 32'd1 : 32'd0);
            tick();
            chk("burst_data", 32'(od), (es == 1) ? 32'(n1) : 32'(n0));
            chk("burst_grant", 32'(grant), (es == 1) ? 32'b10 : 32'b01);
            chk("burst_cnt", 32'(dut.cnt_q), 32'((j % 4) + 1));
            if (es == 1) n1 = n1 + 16'd1;
            else         n0 = n0 + 16'd1;
        end

        // Backpressure for 5 cycles holding src0 beat 0x0307.
        d0 = n0; d1 = n1; ordy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rdy0", 32'(r0), 32'd0);
            chk("bp_rdy1", 32'(r1), 32'd0);
            tick();
            chk("bp_data", 32'(od), 32'h0307);
            chk("bp_val", 32'(ov), 32'd1);
            chk("bp_cnt", 32'(dut.cnt_q), 32'd4);
        end
        ordy = 1'b1; #1;
        chk("resume_rdy1", 32'(r1), 32'd1);
        tick();
        chk("resume_data", 32'(od), 32'h0404);
        chk("resume_grant", 32'(grant), 32'b10);
        chk("resume_cnt", 32'(dut.cnt_q), 32'd1);

        // src1 drops: switch back to src0 so last becomes src0.
        v1 = 1'b0; d0 = 16'h0308;
        tick();
        chk("sw_data", 32'(od), 32'h0308);
        chk("sw_grant", 32'(grant), 32'b01);

        // Mid-stream asynchronous reset with a held beat.
        v0 = 1'b0; ordy = 1'b0; #1;
        chk("mid_val_pre", 32'(ov), 32'd1);
        rst_n = 1'b0; #1;
        chk("mid_val", 32'(ov), 32'd0);
        chk("mid_data", 32'(od), 32'h0);
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        v0 = 1'b1; d0 = 16'h0501; v1 = 1'b1; d1 = 16'h0601; ordy = 1'b1;
        tick();
        chk("post_tie_data", 32'(od), 32'h0501);
        chk("post_tie_grant", 32'(grant), 32'b01);
        v0 = 1'b0; v1 = 1'b0;
        tick();
        chk("final_val", 32'(ov), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
